// File: rtl/sim_mon_pkg.sv
// Shared types and helpers for the simulation test monitor: hart/global state
// encodings and a lowest-set-bit encoder used to pick the first failing hart.
package sim_mon_pkg;

  localparam int MAX_HARTS = 16;
  localparam int IDX_W     = 4;

  typedef enum logic [1:0] {RUN, PASSED, FAILED} hart_st_e;
  typedef enum logic [1:0] {RUNNING, PASS, FAIL, TIMEOUT} glb_st_e;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_HARTS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_HARTS - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sim_mon_hart.sv
// Per-hart verdict FSM: RUN until the first committed ecall, then PASSED or FAILED
// for good; captures the result code of a failing ecall.
module sim_mon_hart
  import sim_mon_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] PASS_CODE = XLEN'(1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_en,
  input  logic            i_ecall,
  input  logic [XLEN-1:0] i_gp,
  input  logic [XLEN-1:0] i_code,
  output logic            o_pass_nxt,
  output logic            o_fail_evt,
  output logic [XLEN-1:0] o_code
);

  hart_st_e        r_state;
  hart_st_e        w_state_nxt;
  logic [XLEN-1:0] r_code;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default to the current state first so no path leaves w_state_nxt unassigned (no latch).
    w_state_nxt = r_state;
    if (i_en && (r_state == RUN) && i_ecall) begin
      w_state_nxt = (i_gp == PASS_CODE) ? PASSED : FAILED;
    end
  end

  assign o_pass_nxt = (w_state_nxt == PASSED);
  assign o_fail_evt = (r_state == RUN) && (w_state_nxt == FAILED);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)           r_code <= '0;
    else if (o_fail_evt) r_code <= i_code;
  end

  assign o_code = r_code;

endmodule

// File: rtl/sim_test_monitor.sv
// Bench monitor deciding PASS/FAIL/TIMEOUT for an N-hart SoC from ecall commits, gp and a
// no-retire watchdog. Optional tohost snooping is enabled by defining SIM_MON_TOHOST_EN.
module sim_test_monitor
  import sim_mon_pkg::*;
#(
  parameter int              HARTS     = 1,
  parameter int              XLEN      = 64,
  parameter int              TIMEOUT_W = 32,
  parameter logic [XLEN-1:0] PASS_CODE = XLEN'(1),
  localparam int             HW        = (HARTS > 1) ? $clog2(HARTS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [HARTS-1:0]      commit_valid,
  input  logic [HARTS-1:0]      ecall_u,
  input  logic [HARTS-1:0]      ecall_s,
  input  logic [HARTS-1:0]      ecall_m,
  input  logic [HARTS*XLEN-1:0] gp,
  input  logic [TIMEOUT_W-1:0]  timeout_cycles,
`ifdef SIM_MON_TOHOST_EN
  input  logic                  tohost_valid,
  input  logic [XLEN-1:0]       tohost_data,
`endif
  output logic                  success,
  output logic                  fail,
  output logic                  timeout,
  output logic                  done,
  output logic [HW-1:0]         fail_hart,
  output logic [XLEN-1:0]       fail_code,
  output logic [TIMEOUT_W-1:0]  cycle_count
);

  glb_st_e               r_glb_st;
  glb_st_e               w_glb_nxt;
  logic                  w_run;
  logic [HARTS-1:0]      w_ecall;
  logic [HARTS-1:0]      w_pass_nxt;
  logic [HARTS-1:0]      w_fail_evt;
  logic [XLEN-1:0]       w_gp       [HARTS];
  logic [XLEN-1:0]       w_code_in  [HARTS];
  logic [XLEN-1:0]       w_code_cap [HARTS];
  logic [IDX_W-1:0]      w_low_idx;
  logic [TIMEOUT_W-1:0]  r_idle;
  logic [TIMEOUT_W-1:0]  w_idle_nxt;
  logic                  w_to_hit;
  logic [TIMEOUT_W-1:0]  r_cycles;
  logic [HW-1:0]         r_fail_hart;

  assign w_run = (r_glb_st == RUNNING);

  always_comb begin
    for (int h = 0; h < HARTS; h++) begin
      w_ecall[h]   = ecall_u[h] | ecall_s[h] | ecall_m[h];
      w_gp[h]      = gp[h*XLEN +: XLEN];
      w_code_in[h] = gp[h*XLEN +: XLEN];
    end
`ifdef SIM_MON_TOHOST_EN
    // A tohost store acts as a hart-0 ecall; odd non-1 values carry the test number in [XLEN-1:1].
    if (tohost_valid) begin
      w_ecall[0]   = 1'b1;
      w_gp[0]      = tohost_data;
      w_code_in[0] = (tohost_data[0] && (tohost_data != XLEN'(1))) ? (tohost_data >> 1)
                                                                     : tohost_data;
    end
`endif
  end

  for (genvar h = 0; h < HARTS; h++) begin : g_hart
    sim_mon_hart #(
      .XLEN      (XLEN),
      .PASS_CODE (PASS_CODE)
    ) u_hart (
      .clock      (clock),
      .reset      (reset),
      .i_en       (w_run),
      .i_ecall    (w_ecall[h]),
      .i_gp       (w_gp[h]),
      .i_code     (w_code_in[h]),
      .o_pass_nxt (w_pass_nxt[h]),
      .o_fail_evt (w_fail_evt[h]),
      .o_code     (w_code_cap[h])
    );
  end

  assign w_low_idx  = lowest_set(MAX_HARTS'(w_fail_evt));
  assign w_idle_nxt = (|commit_valid) ? '0
                    : ((r_idle == '1) ? r_idle : r_idle + TIMEOUT_W'(1));
  assign w_to_hit   = (timeout_cycles != '0) && (w_idle_nxt == timeout_cycles);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_glb_st <= RUNNING;
    else       r_glb_st <= w_glb_nxt;
  end

  // Decisions use the harts' next state and the next idle count so flags land one cycle after the cause.
  always_comb begin
    w_glb_nxt = r_glb_st;
    if (w_run) begin
      if (|w_fail_evt)      w_glb_nxt = FAIL;
      else if (w_to_hit)    w_glb_nxt = TIMEOUT;
      else if (&w_pass_nxt) w_glb_nxt = PASS;
    end
  end

  always_comb begin
    success = (r_glb_st == PASS);
    fail    = (r_glb_st == FAIL);
    timeout = (r_glb_st == TIMEOUT);
    done    = (r_glb_st != RUNNING);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idle      <= '0;
      r_cycles    <= '0;
      r_fail_hart <= '0;
    end else if (w_run) begin
      r_idle <= w_idle_nxt;
      if (r_cycles != '1) r_cycles <= r_cycles + TIMEOUT_W'(1);
      if (|w_fail_evt)    r_fail_hart <= HW'(w_low_idx);
    end
  end

  always_comb begin
    fail_code = '0;
    for (int h = 0; h < HARTS; h++) begin
      if (HW'(h) == r_fail_hart) fail_code = w_code_cap[h];
    end
  end

  assign fail_hart   = r_fail_hart;
  assign cycle_count = r_cycles;

endmodule

// File: tb/tb_sim_test_monitor.sv
// Scoreboard bench for sim_test_monitor: a 1-hart and a 4-hart (6-bit watchdog) instance
// driven from per-scenario tasks.
module tb_sim_test_monitor;

  typedef struct packed {
    logic        s;
    logic        f;
    logic        t;
    logic        d;
    logic [1:0]  h;
    logic [63:0] code;
  } res_t;

  typedef struct {
    string tag;
    res_t  r;
  } sb_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        c1_cv, c1_eu, c1_es, c1_em;
  logic [63:0] c1_gp;
  logic [31:0] c1_to;
  logic        s1, f1, t1, d1;
  logic [0:0]  h1;
  logic [63:0] code1;
  logic [31:0] cyc1;

  logic [3:0]   c4_cv, c4_eu, c4_es, c4_em;
  logic [255:0] c4_gp;
  logic [5:0]   c4_to;
  logic         s4, f4, t4, d4;
  logic [1:0]   h4;
  logic [63:0]  code4;
  logic [5:0]   cyc4;

  sb_t q1[$];
  sb_t q4[$];
  int  total = 0;
  int  bad   = 0;

  sim_test_monitor #(.HARTS(1), .XLEN(64), .TIMEOUT_W(32), .PASS_CODE(64'd1)) dut1 (
    .clock(clock), .reset(reset), .commit_valid(c1_cv), .ecall_u(c1_eu), .ecall_s(c1_es),
    .ecall_m(c1_em), .gp(c1_gp), .timeout_cycles(c1_to), .success(s1), .fail(f1),
    .timeout(t1), .done(d1), .fail_hart(h1), .fail_code(code1), .cycle_count(cyc1)
  );

  sim_test_monitor #(.HARTS(4), .XLEN(64), .TIMEOUT_W(6), .PASS_CODE(64'd1)) dut4 (
    .clock(clock), .reset(reset), .commit_valid(c4_cv), .ecall_u(c4_eu), .ecall_s(c4_es),
    .ecall_m(c4_em), .gp(c4_gp), .timeout_cycles(c4_to), .success(s4), .fail(f4),
    .timeout(t4), .done(d4), .fail_hart(h4), .fail_code(code4), .cycle_count(cyc4)
  );

  function automatic res_t mk(logic s, logic f, logic t, logic d, logic [1:0] h, logic [63:0] c);
    mk = {s, f, t, d, h, c};
  endfunction

  function automatic res_t obs1();
    obs1 = {s1, f1, t1, d1, 1'b0, h1, code1};
  endfunction

  function automatic res_t obs4();
    obs4 = {s4, f4, t4, d4, h4, code4};
  endfunction

  localparam res_t R0 = {1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0};

  task automatic push1(input string tag, input res_t r);
    sb_t e;
    e.tag = tag;
    e.r   = r;
    q1.push_back(e);
  endtask

  task automatic push4(input string tag, input res_t r);
    sb_t e;
    e.tag = tag;
    e.r   = r;
    q4.push_back(e);
  endtask

  task automatic clear_inputs();
    c1_cv = 1'b0; c1_eu = 1'b0; c1_es = 1'b0; c1_em = 1'b0; c1_gp = '0;
    c4_cv = '0;   c4_eu = '0;   c4_es = '0;   c4_em = '0;   c4_gp = '0;
  endtask

  task automatic do_reset(input logic [31:0] to1, input logic [5:0] to4);
    @(negedge clock);
    reset = 1'b1;
    clear_inputs();
    c1_to = to1;
    c4_to = to4;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic drive1(input logic cv, input logic eu, input logic es, input logic em,
                        input logic [63:0] g);
    @(negedge clock);
    c1_cv = cv; c1_eu = eu; c1_es = es; c1_em = em; c1_gp = g;
  endtask

  task automatic drive4(input logic [3:0] cv, input logic [3:0] eu, input logic [3:0] es,
                        input logic [3:0] em, input logic [7:0] g0, input logic [7:0] g1,
                        input logic [7:0] g2, input logic [7:0] g3);
    @(negedge clock);
    c4_cv = cv; c4_eu = eu; c4_es = es; c4_em = em;
    c4_gp = {64'(g3), 64'(g2), 64'(g1), 64'(g0)};
  endtask

  task automatic test_reset();
    sb_t e;
    reset = 1'b1;
    clear_inputs();
    c1_to = '0;
    c4_to = '0;
    push1("reset_1hart", R0);
    push4("reset_4hart", R0);
    #2;
    e = q1.pop_front(); total++;
    if (obs1() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs1(), e.r); end
    e = q4.pop_front(); total++;
    if (obs4() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs4(), e.r); end
    total++;
    if (cyc1 !== 32'd0 || cyc4 !== 6'd0) begin
      bad++; $display("FAIL reset_cycles: got=%0d/%0d want=0/0", cyc1, cyc4);
    end
  endtask

  task automatic test_pass_1hart();
    sb_t e;
    do_reset(32'd0, 6'd0);
    repeat (99) @(posedge clock);
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    push1("pass1_idle_c100", R0);
    @(posedge clock); #1;
    e = q1.pop_front(); total++;
    if (obs1() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs1(), e.r); end
    total++;
    if (cyc1 !== 32'd100) begin bad++; $display("FAIL pass1_cyc100: got=%0d want=100", cyc1); end
    drive1(1'b1, 1'b0, 1'b0, 1'b1, 64'd1);
    push1("pass1_success", mk(1, 0, 0, 1, 2'd0, 64'd0));
    @(posedge clock); #1;
    e = q1.pop_front(); total++;
    if (obs1() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs1(), e.r); end
    total++;
    if (cyc1 !== 32'd101) begin bad++; $display("FAIL pass1_cyc101: got=%0d want=101", cyc1); end
    drive1(1'b0, 1'b1, 1'b0, 1'b0, 64'd3);
    push1("pass1_frozen", mk(1, 0, 0, 1, 2'd0, 64'd0));
    repeat (5) @(posedge clock);
    #1;
    e = q1.pop_front(); total++;
    if (obs1() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs1(), e.r); end
    total++;
    if (cyc1 !== 32'd101) begin bad++; $display("FAIL pass1_cyc_frozen: got=%0d want=101", cyc1); end
  endtask

  task automatic test_fail_1hart();
    sb_t e;
    do_reset(32'd0, 6'd0);
    drive1(1'b1, 1'b0, 1'b0, 1'b0, 64'd5);
    push1("fail1_no_ecall", R0);
    @(posedge clock); #1;
    e = q1.pop_front(); total++;
    if (obs1() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs1(), e.r); end
    drive1(1'b1, 1'b1, 1'b0, 1'b0, 64'h5);
    push1("fail1_ecall_u", mk(0, 1, 0, 1, 2'd0, 64'd5));
    @(posedge clock); #1;
    e = q1.pop_front(); total++;
    if (obs1() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs1(), e.r); end
    drive1(1'b1, 1'b0, 1'b0, 1'b1, 64'd1);
    push1("fail1_later_pass", mk(0, 1, 0, 1, 2'd0, 64'd5));
    @(posedge clock); #1;
    e = q1.pop_front(); total++;
    if (obs1() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs1(), e.r); end
  endtask

  task automatic test_async_reset();
    sb_t e;
    @(posedge clock);
    #2;
    reset = 1'b1;
    clear_inputs();
    push1("async_reset", R0);
    #1;
    e = q1.pop_front(); total++;
    if (obs1() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs1(), e.r); end
    total++;
    if (cyc1 !== 32'd0) begin bad++; $display("FAIL async_reset_cyc: got=%0d want=0", cyc1); end
    @(negedge clock);
    reset = 1'b0;
    drive1(1'b1, 1'b0, 1'b0, 1'b1, 64'd1);
    push1("post_reset_pass", mk(1, 0, 0, 1, 2'd0, 64'd0));
    @(posedge clock); #1;
    e = q1.pop_front(); total++;
    if (obs1() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs1(), e.r); end
  endtask

  task automatic test_multi_pass();
    sb_t e;
    do_reset(32'd0, 6'd0);
    drive4(4'b0001, 4'b0000, 4'b0000, 4'b0001, 8'd1, 8'd0, 8'd0, 8'd0);
    push4("mpass_h0", R0);
    @(posedge clock); #1;
    e = q4.pop_front(); total++;
    if (obs4() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs4(), e.r); end
    drive4(4'b0110, 4'b0100, 4'b0010, 4'b0000, 8'd0, 8'd1, 8'd1, 8'd0);
    push4("mpass_h12", R0);
    @(posedge clock); #1;
    e = q4.pop_front(); total++;
    if (obs4() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs4(), e.r); end
    drive4(4'b0001, 4'b0001, 4'b0000, 4'b0000, 8'd5, 8'd0, 8'd0, 8'd0);
    push4("mpass_h0_ignored", R0);
    @(posedge clock); #1;
    e = q4.pop_front(); total++;
    if (obs4() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs4(), e.r); end
    for (int i = 0; i < 3; i++) begin
      drive4(4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
      push4("mpass_wait_h3", R0);
      @(posedge clock); #1;
      e = q4.pop_front(); total++;
      if (obs4() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs4(), e.r); end
    end
    drive4(4'b1000, 4'b0000, 4'b0000, 4'b1000, 8'd0, 8'd0, 8'd0, 8'd1);
    push4("mpass_all", mk(1, 0, 0, 1, 2'd0, 64'd0));
    @(posedge clock); #1;
    e = q4.pop_front(); total++;
    if (obs4() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs4(), e.r); end
    drive4(4'b1000, 4'b1000, 4'b0000, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd9);
    push4("mpass_frozen", mk(1, 0, 0, 1, 2'd0, 64'd0));
    @(posedge clock); #1;
    e = q4.pop_front(); total++;
    if (obs4() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs4(), e.r); end
  endtask

  task automatic test_multi_fail();
    sb_t e;
    do_reset(32'd0, 6'd0);
    drive4(4'b0111, 4'b0100, 4'b0010, 4'b0001, 8'd1, 8'd7, 8'd9, 8'd0);
    push4("mfail_lowest", mk(0, 1, 0, 1, 2'd1, 64'd7));
    @(posedge clock); #1;
    e = q4.pop_front(); total++;
    if (obs4() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs4(), e.r); end
    drive4(4'b1110, 4'b0000, 4'b0000, 4'b1110, 8'd0, 8'd1, 8'd1, 8'd1);
    push4("mfail_frozen", mk(0, 1, 0, 1, 2'd1, 64'd7));
    @(posedge clock); #1;
    e = q4.pop_front(); total++;
    if (obs4() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs4(), e.r); end
  endtask

  task automatic test_fail_over_pass();
    sb_t e;
    do_reset(32'd0, 6'd0);
    drive4(4'b0011, 4'b0000, 4'b0000, 4'b0011, 8'd1, 8'd1, 8'd0, 8'd0);
    push4("fop_h01_pass", R0);
    @(posedge clock); #1;
    e = q4.pop_front(); total++;
    if (obs4() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs4(), e.r); end
    drive4(4'b1100, 4'b0000, 4'b0000, 4'b1100, 8'd0, 8'd0, 8'd1, 8'd2);
    push4("fop_h3_fail", mk(0, 1, 0, 1, 2'd3, 64'd2));
    @(posedge clock); #1;
    e = q4.pop_front(); total++;
    if (obs4() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs4(), e.r); end
  endtask

  task automatic test_timeout();
    sb_t e;
    do_reset(32'd0, 6'd50);
    repeat (48) @(posedge clock);
    drive4(4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
    push4("to_idle49", R0);
    @(posedge clock); #1;
    e = q4.pop_front(); total++;
    if (obs4() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs4(), e.r); end
    drive4(4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
    push4("to_idle50", mk(0, 0, 1, 1, 2'd0, 64'd0));
    @(posedge clock); #1;
    e = q4.pop_front(); total++;
    if (obs4() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs4(), e.r); end
    drive4(4'b0000, 4'b0001, 4'b0000, 4'b0000, 8'd3, 8'd0, 8'd0, 8'd0);
    push4("to_frozen", mk(0, 0, 1, 1, 2'd0, 64'd0));
    repeat (3) @(posedge clock);
    #1;
    e = q4.pop_front(); total++;
    if (obs4() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs4(), e.r); end
    total++;
    if (cyc4 !== 6'd50) begin bad++; $display("FAIL to_cyc_frozen: got=%0d want=50", cyc4); end

    do_reset(32'd0, 6'd50);
    repeat (48) @(posedge clock);
    drive4(4'b0100, 4'b0000, 4'b0000, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
    push4("to_commit49", R0);
    @(posedge clock); #1;
    e = q4.pop_front(); total++;
    if (obs4() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs4(), e.r); end
    drive4(4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (48) @(posedge clock);
    drive4(4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
    push4("to_restart_idle49", R0);
    @(posedge clock); #1;
    e = q4.pop_front(); total++;
    if (obs4() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs4(), e.r); end
    drive4(4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
    push4("to_restart_idle50", mk(0, 0, 1, 1, 2'd0, 64'd0));
    @(posedge clock); #1;
    e = q4.pop_front(); total++;
    if (obs4() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs4(), e.r); end

    do_reset(32'd0, 6'd50);
    repeat (49) @(posedge clock);
    drive4(4'b0000, 4'b0100, 4'b0000, 4'b0000, 8'd0, 8'd0, 8'd3, 8'd0);
    push4("to_fail_wins", mk(0, 1, 0, 1, 2'd2, 64'd3));
    @(posedge clock); #1;
    e = q4.pop_front(); total++;
    if (obs4() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs4(), e.r); end
  endtask

  task automatic test_cycle_saturate();
    sb_t e;
    do_reset(32'd0, 6'd0);
    drive4(4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
    push4("sat_no_timeout", R0);
    repeat (70) @(posedge clock);
    #1;
    e = q4.pop_front(); total++;
    if (obs4() !== e.r) begin bad++; $display("FAIL %s: got=%h want=%h", e.tag, obs4(), e.r); end
    total++;
    if (cyc4 !== 6'd63) begin bad++; $display("FAIL sat_cycle_count: got=%0d want=63", cyc4); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    test_reset();
    test_pass_1hart();
    test_fail_1hart();
    test_async_reset();
    test_multi_pass();
    test_multi_fail();
    test_fail_over_pass();
    test_timeout();
    test_cycle_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
